// File: rtl/axi4_lite_master_bridge_if.sv
// AXI4-Lite master port bundle for the core bus bridge.
// Master modport drives addresses, data and VALID/READY toward the fabric.
interface axi4_lite_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi4_lite_master_bridge.sv
// Core request port to AXI4-Lite master bridge.
// One outstanding transaction; all bus outputs come straight from flops.
module axi4_lite_master_bridge #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] AXI_PROT   = 3'b000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  axi4_lite_master_bridge_if.master m_axi
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    awvalid;
  logic                    wvalid;
  logic                    bready;
  logic                    arvalid;
  logic                    rready;
  logic                    aw_done;
  logic                    w_done;
  logic                    unused_resp;

  // A channel counts as finished if it already dropped VALID or handshakes now.
  assign aw_done = !awvalid || m_axi.awready;
  assign w_done  = !wvalid  || m_axi.wready;

  assign req_ready = (state == IDLE);

  assign m_axi.awaddr  = awaddr;
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = wdata;
  assign m_axi.wstrb   = wstrb;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;
  assign m_axi.araddr  = araddr;
  assign m_axi.arprot  = AXI_PROT;
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = rready;

  assign unused_resp = m_axi.bresp[0] ^ m_axi.rresp[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      awaddr     <= '0;
      araddr     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_write) begin
              awaddr  <= req_addr;
              wdata   <= req_wdata;
              wstrb   <= req_wstrb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WRITE;
            end else begin
              araddr  <= req_addr;
              arvalid <= 1'b1;
              state   <= RADDR;
            end
          end
        end
        WRITE: begin
          if (awvalid && m_axi.awready) awvalid <= 1'b0;
          if (wvalid && m_axi.wready)   wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            bready <= 1'b1;
            state  <= WRESP;
          end
        end
        WRESP: begin
          if (m_axi.bvalid) begin
            bready     <= 1'b0;
            resp_err   <= m_axi.bresp[1];
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        RADDR: begin
          if (m_axi.arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RDATA;
          end
        end
        RDATA: begin
          if (m_axi.rvalid) begin
            rready     <= 1'b0;
            resp_rdata <= m_axi.rdata;
            resp_err   <= m_axi.rresp[1];
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
